// File: rtl/lrhls_mul_arb_pkg.sv
// Shared types for the LR HLS multiplier arbiter: operand/product typedefs,
// the pipeline stage record and the signed x unsigned product helper.
package lrhls_mul_arb_pkg;

  localparam int A_W      = 18;
  localparam int B_W      = 15;
  localparam int P_W      = A_W + B_W;
  localparam int ID_MAX_W = 3;

  typedef logic signed [A_W-1:0]  opa_t;
  typedef logic        [B_W-1:0]  opb_t;
  typedef logic signed [P_W-1:0]  prod_t;
  typedef logic [ID_MAX_W-1:0]    req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
    opa_t    a;
    opb_t    b;
    prod_t   p;
  } stage_t;

  // b is treated as a non-negative value, so it is zero-extended before the signed multiply.
  function automatic prod_t mul_ab(input opa_t a, input opb_t b);
    prod_t ax;
    prod_t bx;
    ax = {{B_W{a[A_W-1]}}, a};
    bx = {{A_W{1'b0}}, b};
    return ax * bx;
  endfunction

endpackage

// File: rtl/lrhls_mul_pipe.sv
// MUL_LAT-deep multiply pipeline; every stage advances only when en is high,
// so the result at the tail holds steady while the consumer stalls.
module lrhls_mul_pipe
  import lrhls_mul_arb_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int ID_W    = 2
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  input  logic            en,
  input  logic            in_valid,
  input  logic [ID_W-1:0] in_id,
  input  opa_t            a,
  input  opb_t            b,
  output logic            out_valid,
  output logic [ID_W-1:0] out_id,
  output prod_t           p,
  output logic            any_valid
);

  stage_t st_r [MUL_LAT];

  // Stage shift; the product is formed entering stage 2 (stage 1 for a one-deep pipe).
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int k = 0; k < MUL_LAT; k++) begin
        st_r[k] <= '0;
      end
    end else if (en) begin
      st_r[0].valid <= in_valid;
      st_r[0].id    <= req_id_t'(in_id);
      st_r[0].a     <= a;
      st_r[0].b     <= b;
      st_r[0].p     <= (MUL_LAT == 1) ? mul_ab(a, b) : '0;
      for (int k = 1; k < MUL_LAT; k++) begin
        st_r[k]   <= st_r[k-1];
        st_r[k].p <= (k == 1) ? mul_ab(st_r[0].a, st_r[0].b) : st_r[k-1].p;
      end
    end
  end

  // Occupancy flag across all stages
  always_comb begin
    any_valid = 1'b0;
    for (int k = 0; k < MUL_LAT; k++) begin
      any_valid = any_valid | st_r[k].valid;
    end
  end

  assign out_valid = st_r[MUL_LAT-1].valid;
  assign out_id    = st_r[MUL_LAT-1].id[ID_W-1:0];
  assign p         = st_r[MUL_LAT-1].p;

endmodule

// File: rtl/lrhls_mul_arbiter.sv
// Round-robin front end sharing one pipelined 18x15 multiplier among NUM_REQ
// requesters, with a single tagged, back-pressured result bus.
module lrhls_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 3,
  parameter int A_W     = 18,
  parameter int B_W     = 15,
  parameter int P_W     = 33,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*A_W-1:0]    req_a,
  input  logic [NUM_REQ*B_W-1:0]    req_b,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic signed [P_W-1:0]     res_p,
  output logic [ID_W-1:0]           res_id,
  output logic                      busy
);

  import lrhls_mul_arb_pkg::*;

  logic [ID_W-1:0]    ptr_r;
  logic               run_r;
  logic [NUM_REQ-1:0] gnt_s;
  logic [ID_W-1:0]    gnt_id_s;
  logic [ID_W-1:0]    idx_s;
  logic [ID_W:0]      sum_s;
  logic               found_s;
  logic               adv_s;
  logic               xfer_s;
  logic               pipe_valid_s;
  logic [ID_W-1:0]    pipe_id_s;
  prod_t              pipe_p_s;
  logic               any_valid_s;
  opa_t               a_sel_s;
  opb_t               b_sel_s;

  assign adv_s  = !pipe_valid_s || res_ready;
  // run_r keeps req_ready low while reset is held and for the cycle it releases.
  assign xfer_s = found_s & adv_s & run_r;

  // First valid requester at or after ptr_r, wrapping at NUM_REQ
  always_comb begin
    gnt_s    = '0;
    gnt_id_s = '0;
    found_s  = 1'b0;
    sum_s    = '0;
    idx_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = {1'b0, ptr_r} + (ID_W+1)'(k);
      if (sum_s >= (ID_W+1)'(NUM_REQ)) begin
        idx_s = ID_W'(sum_s - (ID_W+1)'(NUM_REQ));
      end else begin
        idx_s = sum_s[ID_W-1:0];
      end
      if (!found_s && req_valid[idx_s]) begin
        found_s       = 1'b1;
        gnt_s[idx_s]  = 1'b1;
        gnt_id_s      = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign req_ready = gnt_s & {NUM_REQ{adv_s & run_r}};
  assign a_sel_s   = req_a[gnt_id_s*A_W +: A_W];
  assign b_sel_s   = req_b[gnt_id_s*B_W +: B_W];

  // Pointer moves one past the requester that just transferred
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr_r <= '0;
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
      if (xfer_s) begin
        ptr_r <= (gnt_id_s == ID_W'(NUM_REQ-1)) ? '0 : gnt_id_s + ID_W'(1);
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  lrhls_mul_pipe #(
    .MUL_LAT (MUL_LAT),
    .ID_W    (ID_W)
  ) u_pipe (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .en        (adv_s),
    .in_valid  (xfer_s),
    .in_id     (gnt_id_s),
    .a         (a_sel_s),
    .b         (b_sel_s),
    .out_valid (pipe_valid_s),
    .out_id    (pipe_id_s),
    .p         (pipe_p_s),
    .any_valid (any_valid_s)
  );

  assign res_valid = pipe_valid_s;
  assign res_id    = pipe_id_s;
  assign res_p     = pipe_p_s;
  assign busy      = any_valid_s;

endmodule

// File: tb/tb_lrhls_mul_arbiter.sv
// Directed bench for lrhls_mul_arbiter: reset, single request, contention,
// backpressure, operand extremes, throughput and mid-flight reset.
module tb_lrhls_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int MUL_LAT = 3;
  localparam int A_W     = 18;
  localparam int B_W     = 15;
  localparam int P_W     = 33;
  localparam int ID_W    = 2;

  logic                   ap_clk = 1'b0;
  logic                   ap_rst_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   res_valid;
  logic                   res_ready;
  logic signed [P_W-1:0]  res_p;
  logic [ID_W-1:0]        res_id;
  logic                   busy;

  int checks = 0;
  int errors = 0;

  logic signed [A_W-1:0] va [16];
  logic [B_W-1:0]        vb [16];
  longint                vp [16];

  lrhls_mul_arbiter #(
    .NUM_REQ (NUM_REQ),
    .MUL_LAT (MUL_LAT),
    .A_W     (A_W),
    .B_W     (B_W),
    .P_W     (P_W),
    .ID_W    (ID_W)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_p     (res_p),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic signed [A_W-1:0] a, input logic [B_W-1:0] b);
    req_a[i*A_W +: A_W] = a;
    req_b[i*B_W +: B_W] = b;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    #3;
    ap_rst_n = 1'b1;
    step();
  endtask

  // Single requester streams n vectors; optional res_ready stall window.
  task automatic stream(input string tag, input int rid, input int n, input int stall_at, input int stall_len);
    int  sent  = 0;
    int  rcvd  = 0;
    int  first = -1;
    int  last  = -1;
    bit  stalled;
    for (int c = 0; c < n + MUL_LAT + stall_len + 4; c++) begin
      stalled   = (c >= stall_at) && (c < stall_at + stall_len);
      res_ready = !stalled;
      req_valid = '0;
      if (sent < n) begin
        req_valid[rid] = 1'b1;
        set_op(rid, va[sent], vb[sent]);
      end
      #1;
      if (stalled) begin
        chk({tag, "_stall_rdy"}, req_ready, 0);
        chk({tag, "_stall_vld"}, res_valid, 1);
        if (rcvd < n) begin
          chk({tag, "_stall_p"}, res_p, vp[rcvd]);
          chk({tag, "_stall_id"}, res_id, rid);
        end
      end else begin
        if (sent < n) chk({tag, "_rdy"}, req_ready, 1 << rid);
        if (res_valid) begin
          if (rcvd < n) begin
            chk({tag, "_p"}, res_p, vp[rcvd]);
            chk({tag, "_id"}, res_id, rid);
          end else begin
            chk({tag, "_extra"}, res_valid, 0);
          end
          if (first < 0) first = c;
          last = c;
          rcvd++;
        end
      end
      if (req_valid[rid] && req_ready[rid]) sent++;
      step();
    end
    chk({tag, "_count"}, rcvd, n);
    chk({tag, "_busy"}, busy, 0);
    if (stall_len == 0) chk({tag, "_span"}, last - first, n - 1);
    req_valid = '0;
    res_ready = 1'b1;
  endtask

  initial begin
    longint t3p [6] = '{300, 303, 306, 309, 312, 315};
    logic signed [A_W-1:0] t4a [4] = '{-18'sd131072, 18'sd131071, -18'sd1, -18'sd1};
    logic [B_W-1:0]        t4b [4] = '{15'd32767, 15'd32767, 15'd0, 15'd1};
    longint                t4p [4] = '{-64'sd4294836224, 64'sd4294803457, 64'sd0, -64'sd1};

    ap_rst_n  = 1'b0;
    req_valid = 4'b1111;
    res_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;

    // Reset state, with every requester asking
    #12;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_p", res_p, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    req_valid = '0;
    ap_rst_n  = 1'b1;
    step();

    // Single request from requester 2
    set_op(2, -18'sd5, 15'd7);
    req_valid = 4'b0100;
    #1;
    chk("t1_rdy", req_ready, 4'b0100);
    step();
    req_valid = '0;
    for (int j = 1; j < MUL_LAT; j++) begin
      chk("t1_early", res_valid, 0);
      step();
    end
    chk("t1_vld", res_valid, 1);
    chk("t1_p", res_p, -35);
    chk("t1_id", res_id, 2);
    step();
    chk("t1_busy_after", busy, 0);
    chk("t1_vld_after", res_valid, 0);

    // Contention: all four requesting for 8 cycles
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 18'(i + 1), 15'd10);
    for (int k = 0; k < 8 + MUL_LAT; k++) begin
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 8) chk("t2_gnt", req_ready, 1 << (k % 4));
      if (k >= MUL_LAT) begin
        chk("t2_vld", res_valid, 1);
        chk("t2_p", res_p, ((k - MUL_LAT) % 4 + 1) * 10);
        chk("t2_id", res_id, (k - MUL_LAT) % 4);
      end
      step();
    end
    chk("t2_drain", res_valid, 0);

    // Backpressure: 6 requests, res_ready low for 5 cycles mid-stream
    for (int k = 0; k < 6; k++) begin
      va[k] = 18'(100 + k);
      vb[k] = 15'd3;
      vp[k] = t3p[k];
    end
    stream("t3", 1, 6, 4, 5);

    // Operand extremes
    for (int k = 0; k < 4; k++) begin
      va[k] = t4a[k];
      vb[k] = t4b[k];
      vp[k] = t4p[k];
    end
    stream("t4", 3, 4, 1000, 0);

    // Throughput: requester 0 alone, 16 back-to-back
    for (int k = 0; k < 16; k++) begin
      va[k] = 18'(k - 8);
      vb[k] = 15'(k * 100);
      vp[k] = longint'(k - 8) * longint'(k * 100);
    end
    stream("t6", 0, 16, 1000, 0);

    // Reset with three products in flight, asserted between clock edges
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 18'(i + 1), 15'd10);
    req_valid = 4'b1111;
    res_ready = 1'b1;
    step();
    step();
    step();
    req_valid = '0;
    #2;
    ap_rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("t5_rst_vld", res_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_rdy", req_ready, 0);
    chk("t5_rst_p", res_p, 0);
    req_valid = '0;
    set_op(2, 18'sd9, 15'd9);
    set_op(3, 18'sd5, 15'd5);
    #2;
    ap_rst_n = 1'b1;
    step();
    chk("t5_no_stale", res_valid, 0);
    req_valid = 4'b1100;
    #1;
    chk("t5_ptr0", req_ready, 4'b0100);
    step();
    req_valid = '0;
    for (int j = 1; j < MUL_LAT; j++) begin
      chk("t5_early", res_valid, 0);
      step();
    end
    chk("t5_vld", res_valid, 1);
    chk("t5_p", res_p, 81);
    chk("t5_id", res_id, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lrhls_mul_arbiter.md
Name: lrhls_mul_arbiter

Overview:
Shares one pipelined 18-bit signed × 15-bit unsigned multiplier among NUM_REQ requesters in the LR HLS datapath. Each requester gets a valid/ready request port. A round-robin arbiter grants at most one request per cycle. Results return on a single tagged output bus with backpressure, so fit-stage consumers can throttle the shared DSP resource without loss.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
MUL_LAT, 3, multiplier pipeline depth in cycles (1..6); also the accept-to-result latency
A_W, 18, signed operand width
B_W, 15, unsigned operand width
P_W, 33, product width (A_W+B_W)
ID_W, 2, requester index width, clog2(NUM_REQ)

Ports:
ap_clk  in  1  clock, all state on rising edge
ap_rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_a  in  NUM_REQ*A_W  flattened signed operands, requester i at [i*A_W +: A_W]
req_b  in  NUM_REQ*B_W  flattened unsigned operands, requester i at [i*B_W +: B_W]
res_valid  out  1  result valid
res_ready  in  1  consumer accept
res_p  out  P_W  signed product
res_id  out  ID_W  index of the requester that issued this product
busy  out  1  any pipeline stage holds valid data

Behaviour:
- Reset (async assert, sync deassert by design): every stage valid bit = 0; RR pointer = 0. res_valid=0, res_p=0, res_id=0, busy=0, req_ready=0.
- Pipeline enable: adv = !res_valid || res_ready. All MUL_LAT stages (data, id, valid) shift only when adv=1. When adv=0 the pipeline freezes and res_valid/res_p/res_id hold stable.
- Arbitration: grant = first i with req_valid[i]=1, searching from ptr upward with wrap. req_ready[i] = grant[i] & adv. This is combinational from req_valid and adv; there is no path from req_ready back into req_valid.
- Request transfer on req_valid[i] & req_ready[i]. On transfer, ptr <= (i+1) mod NUM_REQ. Otherwise ptr holds.
- Stage 1 captures a, b, id and valid=transfer. Stages 2..MUL_LAT carry the product/id/valid.
- Latency: a request accepted in cycle n presents res_valid in cycle n+MUL_LAT if not stalled. Each stall cycle adds one.
- Throughput: one result per cycle while res_ready=1. A bubble (no request) propagates as valid=0.
- Arithmetic: p = signed(a) * signed({1'b0,b}), full P_W bits with no truncation or saturation. Range is -4294836224 .. 4294803457.
- Simultaneous all-valid: the grant rotates strictly through 0,1,..,NUM_REQ-1. No requester waits more than NUM_REQ-1 transfers.
- A requester dropping req_valid before transfer is legal. Request operands are sampled only on transfer.
- Reset mid-operation: in-flight products are discarded and the output deasserts immediately (async).
- busy = OR of all stage valid bits.

Decomposition:
- Package lrhls_mul_arb_pkg holds: A_W/B_W/P_W constants; the operand typedefs (signed A_W, unsigned B_W, signed P_W); the requester id typedef; and a packed stage struct {valid, id, a, b, p}.
- Sub-module lrhls_mul_pipe contains the MUL_LAT-deep, enable-stalled multiply pipeline: inputs en, in_valid, in_id, a, b; outputs out_valid, out_id, p.
- The arbiter, pointer and handshake logic stay in the top.

Test Plan:
1. Single request: requester 2 sends a=-5, b=7 with res_ready=1 → res_valid exactly MUL_LAT cycles later, res_p=-35, res_id=2, busy=0 the cycle after.
2. Contention: all four hold req_valid with a=i+1, b=10 for 8 cycles → grants 0,1,2,3,0,1,2,3; results 10,20,30,40 repeat in that order on consecutive cycles.
3. Backpressure: stream 6 requests, drop res_ready for 5 cycles mid-stream → res_p/res_id frozen while stalled; req_ready=0 while stalled; all 6 results delivered in order, none duplicated.
4. Extremes: (a=-131072, b=32767) → -4294836224; (131071, 32767) → 4294803457; (-1, 0) → 0; (-1, 1) → -1.
5. Reset mid-flight: assert ap_rst_n=0 with 3 results in flight, asynchronous to the clock edge → res_valid, busy and req_ready drop immediately; after release the first request issues with ptr=0 and no stale result appears.
6. Throughput: requester 0 alone, back-to-back 16 requests with res_ready=1 → 16 consecutive res_valid cycles, ptr wraps yet requester 0 is re-granted every cycle.
